// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style receive FIFO with first-word-fall-through head, error tracking, overrun and trigger status.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pe_in,
  input  logic                     fe_in,
  input  logic                     bi_in,
  input  logic                     pop,
  input  logic                     lsr_rd,
  input  logic                     fifo_en,
  input  logic                     clear,
  input  logic [1:0]               rx_trig,
  output logic [7:0]               dout,
  output logic                     pe_out,
  output logic                     fe_out,
  output logic                     bi_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     err_in_fifo,
  output logic                     trig
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L4  = CW'(DEPTH < 4  ? DEPTH : 4);
  localparam logic [CW-1:0] L8  = CW'(DEPTH < 8  ? DEPTH : 8);
  localparam logic [CW-1:0] L14 = CW'(DEPTH < 14 ? DEPTH : 14);
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, err_q, err_d, lvl;
  logic          ovr_q, ovr_d, en_q;
  logic [10:0]   head;
  logic          flush, do_pop, do_push, ovw, we, add_err, sub_err;
  assign head = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign full = fifo_en ? (cnt_q == CW'(DEPTH)) : (cnt_q == CW'(1));
  assign {bi_out, fe_out, pe_out, dout} = empty ? 11'h000 : head;
  assign count = cnt_q;
  assign overrun = ovr_q;
  assign err_in_fifo = err_q != '0;
  assign lvl = rx_trig == 2'b00 ? CW'(1) : rx_trig == 2'b01 ? L4 : rx_trig == 2'b10 ? L8 : L14;
  assign trig = fifo_en ? (cnt_q >= lvl) : ~empty;
  // Toggling fifo_en flushes like an FCR clear; the overwrite path only exists in holding mode.
  always_comb begin
    flush   = clear | (fifo_en ^ en_q);
    do_pop  = pop & ~empty & ~flush;
    do_push = push & (~full | do_pop) & ~flush;
    ovw     = push & full & ~pop & ~fifo_en & ~flush;
    we      = do_push | ovw;
    add_err = we & (pe_in | fe_in | bi_in);
    sub_err = (do_pop | ovw) & (|head[10:8]);
    wr_d    = flush ? '0 : do_push ? (fifo_en ? wr_q + AW'(1) : '0) : wr_q;
    rd_d    = flush ? '0 : do_pop ? (fifo_en ? rd_q + AW'(1) : '0) : rd_q;
    cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    err_d   = flush ? '0 : err_q + CW'(add_err) - CW'(sub_err);
    ovr_d   = (push & full & ~pop & ~flush) | (ovr_q & ~lsr_rd);
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q] <= {bi_in, fe_in, pe_in, din};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= '0;
      ovr_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
      en_q  <= fifo_en;
    end
  end
endmodule
